// File: rtl/dma_mm2s_cmd_issuer.sv
// MM2S command issuer: splits one read request into datamover commands, tracks statuses, reports one completion.
// Optional watchdog enabled by defining DMA_MM2S_CMD_ISSUER_TIMEOUT_EN.
module dma_mm2s_cmd_issuer #(
  parameter int unsigned MAX_CHUNK       = 4194304,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 65536
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          s_req_valid,
  output logic          s_req_ready,
  input  logic [63:0]   s_req_addr,
  input  logic [31:0]   s_req_len,
  input  logic [7:0]    s_req_id,
  output logic [103:0]  m_cmd_tdata,
  output logic          m_cmd_tvalid,
  input  logic          m_cmd_tready,
  input  logic [7:0]    s_sts_tdata,
  input  logic          s_sts_tvalid,
  output logic          s_sts_tready,
  output logic          m_done_valid,
  input  logic          m_done_ready,
  output logic [7:0]    m_done_id,
  output logic [3:0]    m_done_err,
  output logic          busy
);

  localparam int unsigned BTT_W = 23;
  localparam int unsigned OUT_W = 4;
  localparam int unsigned TAG_W = 4;
  localparam logic [31:0]      CHUNK   = 32'(MAX_CHUNK);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [63:0]        addr_q;
  logic [31:0]        rem_q;
  logic [7:0]         id_q;
  logic [3:0]         err_q;
  logic [TAG_W-1:0]   next_tag, exp_tag;
  logic [OUT_W-1:0]   outstanding;

  logic [BTT_W-1:0]   btt;
  logic               last_chunk;
  logic               req_hs, cmd_hs, sts_hs, sts_upd;
  logic               sts_bad;
  logic               timeout_hit;
  logic               active;

  // Current chunk is derived purely from registered state so the command stays stable while stalled.
  assign last_chunk = (rem_q <= CHUNK);
  assign btt        = last_chunk ? BTT_W'(rem_q) : BTT_W'(CHUNK);
  assign active     = (state == ISSUE) || (state == DRAIN);

  assign req_hs  = s_req_valid && s_req_ready;
  assign cmd_hs  = m_cmd_tvalid && m_cmd_tready;
  assign sts_hs  = s_sts_tvalid && s_sts_tready;
  assign sts_upd = sts_hs && active;
  assign sts_bad = (s_sts_tdata[3:0] != exp_tag) || !s_sts_tdata[7];

`ifdef DMA_MM2S_CMD_ISSUER_TIMEOUT_EN
  logic [31:0] wdog;

  // Watchdog only runs while something is in flight and no status has arrived recently.
  assign timeout_hit = active && (outstanding != '0) && !sts_hs
                       && (wdog == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wdog <= '0;
    end else if (req_hs || sts_hs) begin
      wdog <= '0;
    end else if (active && (outstanding != '0)) begin
      wdog <= wdog + 32'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    s_req_ready  = 1'b0;
    m_cmd_tvalid = 1'b0;
    s_sts_tready = 1'b0;
    m_done_valid = 1'b0;
    busy         = 1'b1;
    m_cmd_tdata  = {4'b0, next_tag, addr_q, 1'b0, last_chunk, 6'b0, 1'b1, btt};
    m_done_id    = id_q;
    m_done_err   = err_q;

    case (state)
      IDLE: begin
        s_req_ready = 1'b1;
        busy        = 1'b0;
`ifdef DMA_MM2S_CMD_ISSUER_TIMEOUT_EN
        s_sts_tready = 1'b1;
`endif
        if (s_req_valid) begin
          state_nxt = (s_req_len == 32'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        m_cmd_tvalid = (outstanding < OUT_MAX);
        s_sts_tready = (outstanding != '0);
        if (timeout_hit) begin
          state_nxt = DONE;
        end else if (m_cmd_tvalid && m_cmd_tready && last_chunk) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        s_sts_tready = (outstanding != '0);
        if (timeout_hit) begin
          state_nxt = DONE;
        end else if (s_sts_tvalid && (outstanding == OUT_W'(1))) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        m_done_valid = 1'b1;
        if (m_done_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request context, chunk walker, tag counters and error accumulation.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      addr_q      <= '0;
      rem_q       <= '0;
      id_q        <= '0;
      err_q       <= '0;
      next_tag    <= '0;
      exp_tag     <= '0;
      outstanding <= '0;
    end else if (req_hs) begin
      addr_q      <= s_req_addr;
      rem_q       <= s_req_len;
      id_q        <= s_req_id;
      err_q       <= '0;
      next_tag    <= '0;
      exp_tag     <= '0;
      outstanding <= '0;
    end else begin
      if (cmd_hs) begin
        addr_q   <= addr_q + 64'(btt);
        rem_q    <= rem_q - 32'(btt);
        next_tag <= next_tag + TAG_W'(1);
      end
      if (sts_upd) begin
        err_q   <= err_q | {sts_bad, s_sts_tdata[6:4]};
        exp_tag <= exp_tag + TAG_W'(1);
      end
      case ({cmd_hs, sts_upd})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
      if (timeout_hit) begin
        outstanding <= '0;
        err_q       <= err_q | 4'b1000;
      end
    end
  end

endmodule

// File: tb/tb_dma_mm2s_cmd_issuer.sv
// Self-checking bench for dma_mm2s_cmd_issuer: directed and randomized requests against a chunking/error model.
module tb_dma_mm2s_cmd_issuer;

  localparam int unsigned MAX_CHUNK = 4194304;
  localparam int unsigned MAX_OUT   = 2;
  localparam int unsigned TMO       = 64;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          s_req_valid;
  logic          s_req_ready;
  logic [63:0]   s_req_addr;
  logic [31:0]   s_req_len;
  logic [7:0]    s_req_id;
  logic [103:0]  m_cmd_tdata;
  logic          m_cmd_tvalid;
  logic          m_cmd_tready;
  logic [7:0]    s_sts_tdata;
  logic          s_sts_tvalid;
  logic          s_sts_tready;
  logic          m_done_valid;
  logic          m_done_ready;
  logic [7:0]    m_done_id;
  logic [3:0]    m_done_err;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] sts_plan[$];

  dma_mm2s_cmd_issuer #(
    .MAX_CHUNK(MAX_CHUNK),
    .MAX_OUTSTANDING(MAX_OUT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_addr(s_req_addr), .s_req_len(s_req_len), .s_req_id(s_req_id),
    .m_cmd_tdata(m_cmd_tdata), .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tready(m_cmd_tready),
    .s_sts_tdata(s_sts_tdata), .s_sts_tvalid(s_sts_tvalid), .s_sts_tready(s_sts_tready),
    .m_done_valid(m_done_valid), .m_done_ready(m_done_ready),
    .m_done_id(m_done_id), .m_done_err(m_done_err), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [103:0] obs, input logic [103:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [103:0] mk_cmd(input logic [63:0] a, input logic [22:0] btt,
                                          input logic eof, input logic [3:0] tag);
    return {4'b0, tag, a, 1'b0, eof, 6'b0, 1'b1, btt};
  endfunction

  function automatic logic [7:0] sts_of(input int i);
    if (i < sts_plan.size()) return sts_plan[i];
    return 8'h80 | 8'(i % 16);
  endfunction

  task automatic idle_inputs();
    s_req_valid  = 1'b0;
    m_cmd_tready = 1'b0;
    s_sts_tvalid = 1'b0;
    s_sts_tdata  = 8'h00;
    m_done_ready = 1'b0;
  endtask

  task automatic send_req(input logic [63:0] addr, input logic [31:0] len, input logic [7:0] id);
    bit seen;
    seen = 1'b0;
    s_req_valid = 1'b1;
    s_req_addr  = addr;
    s_req_len   = len;
    s_req_id    = id;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge ap_clk);
      seen = s_req_ready;
      if (!seen) begin
        @(posedge ap_clk);
        #1;
      end
    end
    chk("req_ready", 104'(s_req_ready), 104'(1));
    @(posedge ap_clk);
    #1;
    s_req_valid = 1'b0;
    s_req_addr  = {$urandom, $urandom};
    s_req_len   = $urandom;
  endtask

  // One request end to end; model is the chunk list plus counts of issued/returned commands.
  task automatic run_req(input logic [63:0] addr, input logic [31:0] len, input logic [7:0] id,
                         input int hold, input bit rnd);
    logic [103:0]    exp_q[$];
    logic [63:0]     a;
    longint unsigned left, take;
    logic [3:0]      exp_err;
    logic [7:0]      s;
    int              n, issued, returned;
    bit              finished;
    a = addr;
    left = longint'(len);
    while (left > 0) begin
      take = (left > longint'(MAX_CHUNK)) ? longint'(MAX_CHUNK) : left;
      exp_q.push_back(mk_cmd(a, 23'(take), take == left, 4'(exp_q.size())));
      a = a + 64'(take);
      left = left - take;
    end
    n = exp_q.size();
    exp_err = 4'b0;
    for (int i = 0; i < n; i++) begin
      s = sts_of(i);
      exp_err = exp_err | {(s[3:0] != 4'(i)) || !s[7], s[6:4]};
    end
    send_req(addr, len, id);
    issued = 0;
    returned = 0;
    finished = 1'b0;
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      m_cmd_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m_done_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc >= hold && returned < issued && (!rnd || $urandom_range(0, 3) != 0)) begin
        s_sts_tvalid = 1'b1;
        s_sts_tdata  = sts_of(returned);
      end else begin
        s_sts_tvalid = 1'b0;
        s_sts_tdata  = 8'($urandom);
      end
      @(negedge ap_clk);
      chk("cmd_valid", 104'(m_cmd_tvalid),
          104'(issued < n && (issued - returned) < int'(MAX_OUT)));
      chk("sts_ready", 104'(s_sts_tready), 104'(issued > returned));
      chk("done_valid", 104'(m_done_valid), 104'(issued == n && returned == n));
      chk("busy", 104'(busy), 104'(1));
      if (m_cmd_tvalid && issued < n) chk("cmd_data", m_cmd_tdata, exp_q[issued]);
      if (hold > 0 && cyc == hold - 1)
        chk("held_issue_count", 104'(issued), 104'((n < int'(MAX_OUT)) ? n : int'(MAX_OUT)));
      if (m_done_valid) begin
        chk("done_id", 104'(m_done_id), 104'(id));
        chk("done_err", 104'(m_done_err), 104'(exp_err));
      end
      if (m_cmd_tvalid && m_cmd_tready) issued++;
      if (s_sts_tvalid && s_sts_tready) returned++;
      if (m_done_valid && m_done_ready) finished = 1'b1;
      @(posedge ap_clk);
      #1;
    end
    chk("req_completed", 104'(finished), 104'(1));
    idle_inputs();
    @(negedge ap_clk);
    chk("ready_after_done", 104'(s_req_ready), 104'(1));
    chk("idle_not_busy", 104'(busy), 104'(0));
    @(posedge ap_clk);
    #1;
    sts_plan.delete();
  endtask

  initial begin
    logic [31:0] rlen;
    bit          seen;
    ap_rst = 1'b1;
    s_req_addr = '0;
    s_req_len  = '0;
    s_req_id   = '0;
    idle_inputs();
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_req_ready", 104'(s_req_ready), 104'(1));
    chk("rst_cmd_valid", 104'(m_cmd_tvalid), 104'(0));
    chk("rst_sts_ready", 104'(s_sts_tready), 104'(0));
    chk("rst_done_valid", 104'(m_done_valid), 104'(0));
    chk("rst_busy", 104'(busy), 104'(0));
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;

    // Single short chunk.
    sts_plan = '{8'h80};
    run_req(64'h1000, 32'd100, 8'h5A, 0, 1'b0);

    // Multi-chunk with a short tail.
    sts_plan = '{8'h80, 8'h81, 8'h82, 8'h83};
    run_req(64'h0, 32'(3 * MAX_CHUNK + 5), 8'h11, 0, 1'b0);

    // Zero length goes straight to completion.
    run_req(64'h0, 32'd0, 8'h07, 0, 1'b0);

    // Outstanding limit with statuses withheld.
    run_req(64'h2000, 32'(5 * MAX_CHUNK), 8'h22, 8, 1'b0);

    // Decode error on tag 0, wrong tag on the second status.
    sts_plan = '{8'hA0, 8'h85};
    run_req(64'h3000, 32'(2 * MAX_CHUNK), 8'h33, 0, 1'b0);

    // Exact chunk boundary.
    run_req(64'hFFFF_FFFF_FFC0_0000, 32'(MAX_CHUNK), 8'h44, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      case ($urandom_range(0, 3))
        0:       rlen = 32'($urandom_range(1, 4096));
        1:       rlen = 32'(MAX_CHUNK * $urandom_range(1, 3));
        2:       rlen = 32'(MAX_CHUNK + 1);
        default: rlen = 32'($urandom_range(1, 5 * MAX_CHUNK));
      endcase
      for (int i = 0; i < 6; i++)
        sts_plan.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'h80 | 8'(i % 16)));
      run_req({$urandom, $urandom}, rlen, 8'($urandom), 0, 1'b1);
    end

    // Reset while draining abandons the request silently.
    send_req(64'h4000, 32'(2 * MAX_CHUNK), 8'h55);
    m_cmd_tready = 1'b1;
    repeat (5) @(posedge ap_clk);
    #1;
    @(negedge ap_clk);
    chk("drain_busy", 104'(busy), 104'(1));
    chk("drain_cmd_valid", 104'(m_cmd_tvalid), 104'(0));
    chk("drain_sts_ready", 104'(s_sts_tready), 104'(1));
    #1;
    ap_rst = 1'b1;
    #1;
    chk("midrst_cmd_valid", 104'(m_cmd_tvalid), 104'(0));
    chk("midrst_sts_ready", 104'(s_sts_tready), 104'(0));
    chk("midrst_done_valid", 104'(m_done_valid), 104'(0));
    chk("midrst_req_ready", 104'(s_req_ready), 104'(1));
    chk("midrst_busy", 104'(busy), 104'(0));
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    idle_inputs();
    m_done_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      chk("post_rst_no_done", 104'(m_done_valid), 104'(0));
    end
    @(posedge ap_clk);
    #1;
    m_done_ready = 1'b0;
    run_req(64'h5000, 32'(MAX_CHUNK + 17), 8'h66, 0, 1'b0);

`ifdef DMA_MM2S_CMD_ISSUER_TIMEOUT_EN
    send_req(64'h6000, 32'd100, 8'h77);
    m_cmd_tready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4 * int'(TMO) && !seen; k++) begin
      @(negedge ap_clk);
      seen = m_done_valid;
      if (!seen) begin
        @(posedge ap_clk);
        #1;
      end
    end
    chk("timeout_done", 104'(seen), 104'(1));
    chk("timeout_err3", 104'(m_done_err[3]), 104'(1));
    m_done_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    idle_inputs();
    @(negedge ap_clk);
    chk("idle_sts_ready", 104'(s_sts_tready), 104'(1));
`else
    seen = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
